// File: rtl/packet_rx_pkg.sv
// Shared types and constants for the packet receive deframer.
//   state_t    : deframer FSM states
//   err_code_t : drop reason reported alongside pkt_err
//   SOF_DEFAULT: default start-of-frame marker byte
package packet_rx_pkg;

    typedef enum logic [2:0] {
        ST_HUNT  = 3'd0,
        ST_LEN   = 3'd1,
        ST_PAY   = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_LEN  = 2'b01,
        ERR_CSUM = 2'b10
    } err_code_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/packet_rx_buf.sv
// Payload buffer for the deframer: simple dual-port RAM, DEPTH x 8.
// Ports:
//   clk     : clock
//   wr_en   : write strobe, wr_data stored at wr_addr
//   wr_addr : write address
//   wr_data : write byte
//   rd_en   : read strobe; rd_data updates on the next edge, holds otherwise
//   rd_addr : read address
//   rd_data : registered read byte
module packet_rx_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/packet_rx_deframer.sv
// Byte-serial packet deframer. Frame: SOF, LEN, LEN payload bytes, CSUM where
// CSUM = (LEN + sum of payload) mod 256. Good frames are buffered and released
// downstream; bad-length or bad-checksum frames are dropped whole.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_data     : link byte stream, in_ready = accept
//   out_valid/out_data   : payload stream with out_sop/out_eop, out_ready = accept
//   pkt_ok / pkt_err     : one-cycle result pulses, err_code valid with pkt_err
//   pkt_cnt / err_cnt    : saturating good/dropped frame counters
//
// state    | meaning
// ---------+----------------------------------------------
// ST_HUNT  | discard bytes until SOF
// ST_LEN   | expect length byte, validate 1..MAX_LEN
// ST_PAY   | store payload bytes, accumulate checksum
// ST_CSUM  | compare checksum byte, start prefetch of byte 0
// ST_DRAIN | release buffered payload, input stalled
module packet_rx_deframer
    import packet_rx_pkg::*;
#(
    parameter int         MAX_LEN = 64,
    parameter logic [7:0] SOF     = SOF_DEFAULT,
    parameter int         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_sop,
    output logic             out_eop,
    input  logic             out_ready,
    output logic             pkt_ok,
    output logic             pkt_err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = MAX_LEN[7:0];

    state_t    state, state_nxt;
    err_code_t code_nxt;
    logic      ok_nxt, err_nxt;
    logic [7:0] len_q, wr_ptr, rd_ptr, sum;
    logic       take, out_take, last_out;
    logic       buf_we, buf_re;
    logic [AW-1:0] buf_raddr;

    // Decoded from the state register only, so no path from in_valid.
    assign in_ready  = (state != ST_DRAIN);
    assign take      = in_valid & in_ready;
    assign out_valid = (state == ST_DRAIN);
    assign out_take  = out_valid & out_ready;
    assign last_out  = (rd_ptr == len_q - 8'd1);
    assign out_sop   = out_valid & (rd_ptr == 8'd0);
    assign out_eop   = out_valid & last_out;

    always_comb begin
        state_nxt = state;
        ok_nxt    = 1'b0;
        err_nxt   = 1'b0;
        code_nxt  = ERR_NONE;
        buf_we    = 1'b0;
        buf_re    = 1'b0;
        buf_raddr = AW'(rd_ptr + 8'd1);
        case (state)
            ST_HUNT: begin
                if (take && in_data == SOF) state_nxt = ST_LEN;
            end
            ST_LEN: begin
                if (take) begin
                    if (in_data == 8'd0 || in_data > MAX_LEN_B) begin
                        err_nxt   = 1'b1;
                        code_nxt  = ERR_LEN;
                        state_nxt = ST_HUNT;
                    end else begin
                        state_nxt = ST_PAY;
                    end
                end
            end
            ST_PAY: begin
                if (take) begin
                    buf_we = 1'b1;
                    if (wr_ptr == len_q - 8'd1) state_nxt = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (take) begin
                    // Prefetch byte 0 so out_data is ready in the first DRAIN cycle.
                    buf_re    = 1'b1;
                    buf_raddr = '0;
                    if (in_data == sum) begin
                        ok_nxt    = 1'b1;
                        state_nxt = ST_DRAIN;
                    end else begin
                        err_nxt   = 1'b1;
                        code_nxt  = ERR_CSUM;
                        state_nxt = ST_HUNT;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_take) begin
                    if (last_out) state_nxt = ST_HUNT;
                    else          buf_re    = 1'b1;
                end
            end
            default: state_nxt = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_HUNT;
            pkt_ok   <= 1'b0;
            pkt_err  <= 1'b0;
            err_code <= ERR_NONE;
            pkt_cnt  <= '0;
            err_cnt  <= '0;
            len_q    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sum      <= '0;
        end else begin
            state    <= state_nxt;
            pkt_ok   <= ok_nxt;
            pkt_err  <= err_nxt;
            err_code <= code_nxt;
            if (ok_nxt && pkt_cnt != '1)  pkt_cnt <= pkt_cnt + 1'b1;
            if (err_nxt && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            if (state == ST_LEN && take) begin
                len_q  <= in_data;
                sum    <= in_data;
                wr_ptr <= '0;
            end
            if (state == ST_PAY && take) begin
                sum    <= sum + in_data;
                wr_ptr <= wr_ptr + 8'd1;
            end
            if (state == ST_CSUM && take)  rd_ptr <= '0;
            if (out_take)                  rd_ptr <= rd_ptr + 8'd1;
        end
    end

    packet_rx_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (in_data),
        .rd_en   (buf_re),
        .rd_addr (buf_raddr),
        .rd_data (out_data)
    );

endmodule

// File: doc/packet_rx_deframer.md
Name: packet_rx_deframer

Overview:
- Receive end of the team's byte-serial packet link; the inverse of the packet framer that the bench packet items model.
- Hunts for start-of-frame, captures length and payload into an internal buffer, and verifies the checksum.
- Releases a packet downstream only if the checksum is good; bad or malformed frames are dropped whole.
- Sits between the link byte interface and the payload consumer.

Parameters:
- MAX_LEN, 64, maximum payload bytes per packet (1..255)
- SOF, 8'hA5, start-of-frame marker byte
- CNT_W, 16, width of the saturating packet/error counters

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input byte valid
- in_data  in  8  input byte
- in_ready  out  1  deframer accepts byte (transfer = in_valid & in_ready)
- out_valid  out  1  payload byte valid
- out_data  out  8  payload byte
- out_sop  out  1  first payload byte of packet
- out_eop  out  1  last payload byte of packet
- out_ready  in  1  consumer accepts byte (transfer = out_valid & out_ready)
- pkt_ok  out  1  one-cycle pulse: good packet accepted
- pkt_err  out  1  one-cycle pulse: frame dropped
- err_code  out  2  valid with pkt_err: 01 = bad length, 10 = checksum mismatch
- pkt_cnt  out  CNT_W  good packets, saturating
- err_cnt  out  CNT_W  dropped frames, saturating

Behaviour:
- Frame format: SOF, LEN, LEN payload bytes, CSUM. CSUM = (LEN + sum of payload) mod 256.
- Reset (rst sampled high): state HUNT; in_ready=1; out_valid, out_sop, out_eop, pkt_ok, pkt_err=0; err_code=0; counters=0; buffer contents are don't-care.
- HUNT: in_ready=1. A byte equal to SOF moves to LEN; any other byte is discarded with no error.
- LEN: when LEN==0 or LEN>MAX_LEN, pulse pkt_err with err_code=01 next cycle, increment err_cnt, go to HUNT. Otherwise latch len, seed sum=LEN, set wr_ptr=0, go to PAY.
- PAY: each accepted byte is written to buf[wr_ptr], sum+=byte, wr_ptr++. After byte number len, go to CSUM.
- CSUM: byte == sum[7:0] -> DRAIN; next cycle pkt_ok=1 and pkt_cnt++. Mismatch -> pkt_err=1 with err_code=10, err_cnt++, go to HUNT.
- A byte equal to SOF inside LEN, PAY or CSUM is treated as data; there is no resync mid-frame.
- DRAIN: in_ready=0. out_valid=1 from the first DRAIN cycle, which is the cycle after the CSUM byte is accepted. Latency CSUM accept -> first out_valid is 1 cycle, coincident with pkt_ok.
- Buffer read is registered; out_data must be valid in the same cycle as out_valid, so prefetch (buffer read ahead).
- out_sop=1 on byte 0 and out_eop=1 on byte len-1; both are high together when len==1.
- out_valid/out_data/out_sop/out_eop hold stable while out_ready=0.
- After the eop transfer: next state HUNT, in_ready=1 the following cycle.
- in_ready is a registered function of state only; it never depends combinationally on in_valid.
- Counters saturate at all-ones and do not wrap.
- pkt_ok and pkt_err are never high in the same cycle.
- Reset mid-frame or mid-DRAIN: packet is lost, no pkt_ok/pkt_err generated, outputs take reset values next cycle.
- in_valid gaps (bubbles) are allowed in any state and do not affect the frame.

Decomposition:
- Shared package packet_rx_pkg: state enum (HUNT, LEN, PAY, CSUM, DRAIN); err_code enum (ERR_NONE=00, ERR_LEN=01, ERR_CSUM=10); default SOF constant.
- Sub-module packet_rx_buf: simple dual-port RAM, MAX_LEN x 8, one write port, one registered read port.

Test Plan:
- Good packet: in A5 03 11 22 33 69, out_ready=1 -> pkt_ok one cycle after the 69 byte; out 11(sop) 22 33(eop); pkt_cnt=1.
- Checksum error: A5 03 11 22 33 68 -> pkt_err with err_code=10; no out_valid; err_cnt=1; next A5 01 7F 80 -> out 7F with sop=eop=1.
- Length errors: A5 00 and A5 41 (MAX_LEN=64) -> two pkt_err pulses with err_code=01; err_cnt=2; garbage 00 FF before SOF is ignored silently.
- Backpressure: good 4-byte packet with out_ready toggling 1010 -> data and flags stable while stalled; in_ready=0 until eop transfer, then 1 next cycle.
- Boundary: MAX_LEN=64 packet of payload 0..63 -> all 64 bytes output in order with correct sop/eop; payload containing A5 is not treated as SOF.
- Reset mid-DRAIN after 2 of 3 bytes output -> outputs return to reset values the next cycle; pkt_cnt=0; the following good packet passes normally.
